spi_slave_mem: RTL

SPI_SLAVE_MEM -- requirements
Module: spi_slave_mem

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/spi_slave_sync.sv | 32 +++
 rtl/spi_slave_mem.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared opcodes and FSM state encoding for the SPI byte-register slave.
package spi_slave_pkg;

   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_STAT  = 8'h05;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_DISCARD,
      ST_STAT
   } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, with one-cycle
// rise/fall pulses derived from the synchronized level.
module spi_slave_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_reg;
   logic              prev_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         chain_reg <= {STAGES{RST_VAL}};
         prev_reg  <= RST_VAL;
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], din};
         prev_reg  <= chain_reg[STAGES-1];
      end
   end

   assign sync = chain_reg[STAGES-1];
   assign rise = sync & ~prev_reg;
   assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave exposing MEM_DEPTH byte registers (write 0x02, read 0x03).
// Define SPI_SLAVE_STATUS_EN to enable opcode 0x05 (saturating write-transfer count).
module spi_slave_mem
   import spi_slave_pkg::*;
#(
   parameter int MEM_DEPTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic ref_clk,
   input  logic pad_reset,
   input  logic spim_sck_i,
   input  logic spim_csn_i,
   input  logic spim_mosi_i,
   output logic spim_miso_o,
   output logic spim_miso_oe_o,
   output logic xfer_done_o,
   output logic cmd_err_o
);

   localparam int         AW     = $clog2(MEM_DEPTH);
   localparam logic [7:0] SETTLE = 8'(SYNC_STAGES + 1);

   logic                   sck_sync, sck_rise, sck_fall;
   logic                   csn_sync, csn_rise, csn_fall;
   logic [SYNC_STAGES-1:0] mosi_chain_reg;
   logic                   mosi_sync;
   state_t                 state_reg, state_next;
   logic [2:0]             bit_cnt_reg;
   logic [6:0]             rx_shift_reg;
   logic [7:0]             rx_byte, tx_shift_reg, tx_value;
   logic [AW-1:0]          addr_reg, addr_next;
   logic [7:0]             mem_reg [MEM_DEPTH];
   logic                   op_read_reg, byte_seen_reg, armed_reg;
   logic [7:0]             settle_reg;
   logic                   xfer_done_reg, cmd_err_reg;
   logic                   sample_en, byte_done, mem_we, tx_load, err_next;

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(ref_clk), .srst(pad_reset), .din(spim_sck_i),
      .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
   );

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
      .clk(ref_clk), .srst(pad_reset), .din(spim_csn_i),
      .sync(csn_sync), .rise(csn_rise), .fall(csn_fall)
   );

   always_ff @(posedge ref_clk) begin
      if (pad_reset) mosi_chain_reg <= '0;
      else           mosi_chain_reg <= {mosi_chain_reg[SYNC_STAGES-2:0], spim_mosi_i};
   end
   assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];

   // csn_rise always implies csn_sync high, so the csn term also lets csn win a tie.
   assign sample_en = sck_rise && sck_sync && !csn_sync && (state_reg != ST_IDLE);
   assign byte_done = sample_en && (bit_cnt_reg == 3'd7);
   assign rx_byte   = {rx_shift_reg, mosi_sync};

`ifdef SPI_SLAVE_STATUS_EN
   logic [7:0] wr_count_reg;
   logic       wrote_reg;

   always_ff @(posedge ref_clk) begin
      if (pad_reset) begin
         wr_count_reg <= '0;
         wrote_reg    <= 1'b0;
      end else begin
         if (csn_rise || csn_fall) wrote_reg <= 1'b0;
         else if (mem_we)          wrote_reg <= 1'b1;
         if (csn_rise && wrote_reg && (wr_count_reg != 8'hFF))
            wr_count_reg <= wr_count_reg + 8'd1;
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      tx_value   = tx_shift_reg;
      mem_we     = 1'b0;
      tx_load    = 1'b0;
      err_next   = 1'b0;
      if (csn_rise) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: if (csn_fall && armed_reg) state_next = ST_CMD;
            ST_CMD: if (byte_done) begin
               if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                  state_next = ST_ADDR;
`ifdef SPI_SLAVE_STATUS_EN
               end else if (rx_byte == OP_STAT) begin
                  state_next = ST_STAT;
                  tx_load    = 1'b1;
                  tx_value   = wr_count_reg;
`endif
               end else begin
                  state_next = ST_DISCARD;
                  err_next   = 1'b1;
               end
            end
            ST_ADDR: if (byte_done) begin
               addr_next = rx_byte[AW-1:0];
               if (op_read_reg) begin
                  state_next = ST_RDATA;
                  tx_load    = 1'b1;
                  tx_value   = mem_reg[rx_byte[AW-1:0]];
                  addr_next  = rx_byte[AW-1:0] + AW'(1);
               end else begin
                  state_next = ST_WDATA;
               end
            end
            ST_WDATA: if (byte_done) begin
               mem_we    = 1'b1;
               addr_next = addr_reg + AW'(1);
            end
            ST_RDATA: if (byte_done) begin
               tx_load   = 1'b1;
               tx_value  = mem_reg[addr_reg];
               addr_next = addr_reg + AW'(1);
            end
`ifdef SPI_SLAVE_STATUS_EN
            ST_STAT: if (byte_done) begin
               tx_load  = 1'b1;
               tx_value = wr_count_reg;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge ref_clk) begin
      if (pad_reset) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         bit_cnt_reg   <= '0;
         rx_shift_reg  <= '0;
         tx_shift_reg  <= '0;
         op_read_reg   <= 1'b0;
         byte_seen_reg <= 1'b0;
         xfer_done_reg <= 1'b0;
         cmd_err_reg   <= 1'b0;
         settle_reg    <= '0;
         armed_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         cmd_err_reg   <= err_next;
         xfer_done_reg <= csn_rise && byte_seen_reg;
         // Arm only once csn is seen high through a freshly refilled synchronizer,
         // so a transfer cut by reset is not resumed mid-stream.
         if (settle_reg != SETTLE)            settle_reg <= settle_reg + 8'd1;
         if ((settle_reg == SETTLE) && csn_sync) armed_reg <= 1'b1;
         if (csn_rise || csn_fall) bit_cnt_reg <= '0;
         else if (sample_en)       bit_cnt_reg <= bit_cnt_reg + 3'd1;
         if (sample_en) rx_shift_reg <= rx_byte[6:0];
         if (csn_rise || csn_fall) byte_seen_reg <= 1'b0;
         else if (byte_done)       byte_seen_reg <= 1'b1;
         if (state_reg == ST_CMD && byte_done) op_read_reg <= (rx_byte == OP_READ);
         if (csn_rise)     tx_shift_reg <= '0;
         else if (tx_load) tx_shift_reg <= tx_value;
         else if (sck_fall && !csn_sync && (bit_cnt_reg != 3'd0))
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_mem
         always_ff @(posedge ref_clk) begin
            if (pad_reset)                             mem_reg[gi] <= '0;
            else if (mem_we && (addr_reg == AW'(gi)))  mem_reg[gi] <= rx_byte;
         end
      end
   endgenerate

   assign spim_miso_oe_o = ((state_reg == ST_RDATA) || (state_reg == ST_STAT)) && !csn_sync;
   assign spim_miso_o    = spim_miso_oe_o && tx_shift_reg[7];
   assign xfer_done_o    = xfer_done_reg;
   assign cmd_err_o      = cmd_err_reg;

endmodule
